// File: rtl/tx_fifo_rd_pkg.sv
// Shared types and constants for the PCS TX FIFO read-side drain controller.
package tx_fifo_rd_pkg;

  typedef enum logic {
    WAIT   = 1'b0,
    STREAM = 1'b1
  } rd_state_t;

  localparam int BUF_DEPTH = 2;

  // Idle control block emitted whenever no FIFO word is available.
  localparam logic [65:0] DEFAULT_IDLE_WORD = {2'b10, 64'h1E};

endpackage

// File: rtl/tx_rd_skid_buf.sv
// Two-entry ordered buffer: entry 0 is always the head. Supports simultaneous
// push and pop without disturbing word order.
module tx_rd_skid_buf
  import tx_fifo_rd_pkg::*;
#(
  parameter int DATA_WIDTH = 66
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  push,
  input  logic                  pop,
  input  logic [DATA_WIDTH-1:0] din,
  output logic [DATA_WIDTH-1:0] head,
  output logic [1:0]            occ
);

  logic [DATA_WIDTH-1:0] mem [BUF_DEPTH];
  logic [1:0]            occ_reg;
  logic [1:0]            occ_next;

  always_comb begin
    occ_next = occ_reg;
    if (push && !pop) begin
      occ_next = occ_reg + 2'd1;
    end else if (pop && !push) begin
      occ_next = occ_reg - 2'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      occ_reg <= 2'd0;
    end else begin
      occ_reg <= occ_next;
    end
  end

  // Data storage carries no reset; occ alone decides which entries are live.
  always_ff @(posedge clk) begin
    if (pop) begin
      mem[0] <= (push && occ_reg == 2'd1) ? din : mem[1];
    end else if (push && occ_reg == 2'd0) begin
      mem[0] <= din;
    end
    if (push && ((occ_reg == 2'd1 && !pop) || (occ_reg == 2'd2 && pop))) begin
      mem[1] <= din;
    end
  end

  assign head = mem[0];
  assign occ  = occ_reg;

  a_no_overflow : assert property (@(posedge clk) disable iff (rst)
    !(push && !pop && occ_reg == 2'(BUF_DEPTH)));
  a_no_underflow : assert property (@(posedge clk) disable iff (rst)
    !(pop && occ_reg == 2'd0));

endmodule

// File: rtl/tx_fifo_rd_ctrl.sv
// Read-side drain controller for the PCS TX clock-crossing FIFO.
// Optional macro UNDERRUN_CNT_EN builds the saturating underrun event counter.
module tx_fifo_rd_ctrl
  import tx_fifo_rd_pkg::*;
#(
  parameter int                    DATA_WIDTH = 66,
  parameter int                    START_DLY  = 4,
  parameter logic [DATA_WIDTH-1:0] IDLE_WORD  = DATA_WIDTH'(DEFAULT_IDLE_WORD)
) (
  input  logic                  rclk,
  input  logic                  rrst,
  input  logic                  rempty,
  input  logic [DATA_WIDTH-1:0] rdata,
  output logic                  rinc,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_idle,
  input  logic                  out_ready,
  output logic [15:0]           underrun_cnt
);

  localparam logic [7:0] START_LAST = 8'(START_DLY - 1);

  rd_state_t             state_reg;
  rd_state_t             state_next;
  logic [7:0]            start_cnt_reg;
  logic [7:0]            start_cnt_next;
  logic                  inflight_reg;
  logic [1:0]            occ;
  logic [DATA_WIDTH-1:0] head;
  logic                  have_word;
  logic                  pop;
  logic                  underrun;
  logic [2:0]            credit;

  tx_rd_skid_buf #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_buf (
    .clk  (rclk),
    .rst  (rrst),
    .push (inflight_reg),
    .pop  (pop),
    .din  (rdata),
    .head (head),
    .occ  (occ)
  );

  assign have_word = (state_reg == STREAM) && (occ != 2'd0);
  assign pop       = have_word && out_ready;
  assign out_data  = have_word ? head : IDLE_WORD;
  assign out_idle  = !have_word;

  // Credit counts words held plus the one in flight, minus the one leaving now.
  assign credit = 3'(occ) + 3'(inflight_reg) - 3'(pop);
  assign rinc   = (state_reg == STREAM) && !rempty && (credit < 3'(BUF_DEPTH));

  // An in-flight word does not count: the encoder wants a word this cycle.
  assign underrun = (state_reg == STREAM) && out_ready && (occ == 2'd0);

  always_comb begin
    state_next     = state_reg;
    start_cnt_next = start_cnt_reg;
    case (state_reg)
      WAIT: begin
        if (rempty) begin
          start_cnt_next = 8'd0;
        end else if (start_cnt_reg == START_LAST) begin
          state_next = STREAM;
        end else begin
          start_cnt_next = start_cnt_reg + 8'd1;
        end
      end
      STREAM: begin
        if (underrun) begin
          state_next     = WAIT;
          start_cnt_next = 8'd0;
        end
      end
      default: begin
        state_next     = WAIT;
        start_cnt_next = 8'd0;
      end
    endcase
  end

  always_ff @(posedge rclk or posedge rrst) begin
    if (rrst) begin
      state_reg     <= WAIT;
      start_cnt_reg <= 8'd0;
      inflight_reg  <= 1'b0;
    end else begin
      state_reg     <= state_next;
      start_cnt_reg <= start_cnt_next;
      inflight_reg  <= rinc;
    end
  end

`ifdef UNDERRUN_CNT_EN
  logic [15:0] underrun_cnt_reg;

  always_ff @(posedge rclk or posedge rrst) begin
    if (rrst) begin
      underrun_cnt_reg <= 16'h0000;
    end else if (underrun && underrun_cnt_reg != 16'hFFFF) begin
      underrun_cnt_reg <= underrun_cnt_reg + 16'd1;
    end
  end

  assign underrun_cnt = underrun_cnt_reg;
`else
  assign underrun_cnt = 16'h0000;
`endif

endmodule

// File: tb/tb_tx_fifo_rd_ctrl.sv
// Randomised scoreboard bench for tx_fifo_rd_ctrl against a queue-based reference model.
module tb_tx_fifo_rd_ctrl;

  localparam int             DW   = 66;
  localparam int             SD   = 4;
  localparam logic [DW-1:0]  IDLE = {2'b10, 64'h1E};

  logic          rclk = 1'b0;
  logic          rrst;
  logic          rempty;
  logic [DW-1:0] rdata;
  logic          rinc;
  logic [DW-1:0] out_data;
  logic          out_idle;
  logic          out_ready;
  logic [15:0]   underrun_cnt;

  always #5 rclk = ~rclk;

  tx_fifo_rd_ctrl #(
    .DATA_WIDTH(DW),
    .START_DLY (SD),
    .IDLE_WORD (IDLE)
  ) dut (
    .rclk        (rclk),
    .rrst        (rrst),
    .rempty      (rempty),
    .rdata       (rdata),
    .rinc        (rinc),
    .out_data    (out_data),
    .out_idle    (out_idle),
    .out_ready   (out_ready),
    .underrun_cnt(underrun_cnt)
  );

  typedef struct {
    logic          rinc;
    logic          idle;
    logic [DW-1:0] data;
    logic [15:0]   ucnt;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  // Reference model: streaming flag, consecutive non-empty count, word queue.
  bit            m_stream;
  int            m_prime;
  logic [DW-1:0] m_buf[$];
  bit            m_infl;
  int            m_ucnt;
  int            n_under;
  int            n_words;

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, req, $time);
    end
  endtask

  function automatic void model_reset();
    m_stream = 1'b0;
    m_prime  = 0;
    m_buf.delete();
    m_infl   = 1'b0;
    m_ucnt   = 0;
  endfunction

  // Drive one cycle of stimulus and push the expected response for that cycle.
  task automatic step(input bit e, input bit r);
    exp_t x;
    bit   pop;
    bit   under;
    @(posedge rclk);
    #1;
    rempty    = e;
    out_ready = r;
    rdata     = {2'($urandom), $urandom, $urandom};
    x.idle  = !(m_stream && m_buf.size() > 0);
    x.data  = x.idle ? IDLE : m_buf[0];
    pop     = m_stream && (m_buf.size() > 0) && r;
    x.rinc  = m_stream && !e && ((m_buf.size() + int'(m_infl) - int'(pop)) < 2);
    under   = m_stream && r && (m_buf.size() == 0);
`ifdef UNDERRUN_CNT_EN
    x.ucnt  = 16'(m_ucnt);
`else
    x.ucnt  = 16'h0000;
`endif
    exp_q.push_back(x);
    if (pop) begin
      void'(m_buf.pop_front());
      n_words++;
    end
    if (m_infl) m_buf.push_back(rdata);
    m_infl = x.rinc;
    if (!m_stream) begin
      if (e) m_prime = 0;
      else if (m_prime + 1 >= SD) m_stream = 1'b1;
      else m_prime++;
    end else if (under) begin
      m_stream = 1'b0;
      m_prime  = 0;
    end
    if (under) begin
      n_under++;
      if (m_ucnt < 65535) m_ucnt++;
    end
  endtask

  task automatic do_reset(input int cycles);
    @(negedge rclk);
    #1;
    rempty    = 1'b1;
    out_ready = 1'b0;
    rrst      = 1'b1;
    #1;
    check("rst_rinc", DW'(rinc), DW'(1'b0));
    check("rst_out_idle", DW'(out_idle), DW'(1'b1));
    check("rst_out_data", out_data, IDLE);
    check("rst_underrun_cnt", DW'(underrun_cnt), DW'(16'h0000));
    model_reset();
    repeat (cycles) @(posedge rclk);
    @(negedge rclk);
    #1;
    rrst = 1'b0;
  endtask

  always @(negedge rclk) begin
    exp_t x;
    if (exp_q.size() > 0) begin
      x = exp_q.pop_front();
      check("rinc", DW'(rinc), DW'(x.rinc));
      check("out_idle", DW'(out_idle), DW'(x.idle));
      check("out_data", out_data, x.data);
      check("underrun_cnt", DW'(underrun_cnt), DW'(x.ucnt));
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout: bench did not finish, got running expected done");
    $fatal(1, "timeout");
  end

  initial begin
    rrst      = 1'b0;
    rempty    = 1'b1;
    out_ready = 1'b0;
    rdata     = '0;
    n_under   = 0;
    n_words   = 0;
    model_reset();

    // Idle after reset with an empty FIFO.
    do_reset(3);
    repeat (20) step(1'b1, 1'b1);

    // Priming, first fetch and sustained streaming.
    repeat (9) step(1'b1, 1'b1);
    repeat (40) step(1'b0, 1'b1);

    // Back-pressure fills the buffer, then release.
    repeat (8) step(1'b0, 1'b0);
    repeat (15) step(1'b0, 1'b1);

    // FIFO runs dry while the encoder keeps pulling.
    repeat (10) step(1'b0, 1'b0);
    repeat (12) step(1'b1, 1'b1);

    // Mixed random traffic.
    for (int i = 0; i < 400; i++) begin
      step($urandom_range(0, 4) == 0, $urandom_range(0, 3) != 0);
    end

    // Reset while the buffer is full; old words must never reappear.
    repeat (12) step(1'b0, 1'b0);
    do_reset(2);
    repeat (30) step(1'b0, $urandom_range(0, 1) == 1);

    // Long full-rate bursts separated by gaps.
    for (int i = 0; i < 300; i++) begin
      step((i % 50) > 44, (i % 17) != 3);
    end

    @(negedge rclk);
    #2;
    check("exp_queue_drained", DW'(exp_q.size()), DW'(0));
    $display("info: %0d words delivered, %0d underruns modelled", n_words, n_under);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
